// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencer between the MEM stage and a data memory.
// It accepts one load or store at a time and checks its alignment. It
// presents a word address, byte enables and lane-shifted store data to the
// memory and holds them until the grant. It then waits for read data and
// returns exactly one response per accepted request. Every output is decoded
// from state and latched fields only, so no input reaches an output
// combinationally.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255  // ISSUE+WAIT cycle budget, 1..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd7;

  // The count reaches TIMEOUT at the end of the cycle in which it reads TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW:         return SZ_WORD;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op_size(op))
      SZ_WORD: return a != 2'b00;
      SZ_HALF: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic        accept;
  logic        capture;
  logic        timeout_fire;
  logic        timeout_hit;
  logic        is_store;
  size_t       size_q;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [3:0]  byteen;
  logic [31:0] lane_wdata;

  assign req_ready   = (state_q == S_IDLE);
  assign accept      = req_valid && req_ready;
  assign capture     = (state_q == S_WAIT) && mem_rvalid;
  assign timeout_hit = (cnt_q >= TO_LAST);
  // A grant or rvalid in the same cycle as the timeout wins.
  assign timeout_fire = timeout_hit &&
                        (((state_q == S_ISSUE) && !mem_gnt) ||
                         ((state_q == S_WAIT) && !mem_rvalid));
  assign is_store = (op_q >= OP_SW);
  assign size_q   = op_size(op_q);

  // State register; reset aborts any access in flight without a response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = is_misaligned(req_op, req_addr[1:0]) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_gnt)           state_d = is_store ? S_RESP : S_WAIT;
        else if (timeout_hit)  state_d = S_RESP;
      end
      S_WAIT: begin
        if (mem_rvalid || timeout_hit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields, response data/error and the timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= is_misaligned(req_op, req_addr[1:0]);
        cnt_q   <= '0;
      end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (capture)      rdata_q <= load_data;
      if (timeout_fire) err_q   <= 1'b1;
    end
  end

  // Lane selection and sign/zero extension of the returned word.
  assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = rd_shift;
    case (op_q)
      OP_LB:   load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_data = {24'h0, rd_shift[7:0]};
      OP_LH:   load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Byte enables and lane-shifted store data from the latched access.
  always_comb begin
    byteen     = 4'b1111;
    lane_wdata = wdata_q;
    case (size_q)
      SZ_HALF: begin
        byteen     = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = addr_q[1] ? {wdata_q[15:0], 16'h0} : {16'h0, wdata_q[15:0]};
      end
      SZ_BYTE: begin
        byteen     = 4'b0001 << addr_q[1:0];
        lane_wdata = 32'(wdata_q[7:0]) << {addr_q[1:0], 3'b000};
      end
      default: begin
        byteen     = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Memory side is only driven while the request is outstanding.
  assign mem_req    = (state_q == S_ISSUE);
  assign mem_we     = mem_req && is_store;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_byteen = mem_req ? byteen : 4'h0;
  assign mem_wdata  = mem_req ? lane_wdata : 32'h0;

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
